io_intr_timer: RTL and testbench

- Memory-mapped I/O peripheral on the CPU's data/IO bus; responds when the CPU asserts io_cs with io_rd or io_wr.
- Contains a 256-word scratch RAM and a programmable down-counter that raises intr toward the CPU.
- Completes a two-phase intr/inta handshake with the CPU control unit and keeps an acknowledge count for software.

---
 rtl/io_intr_timer_if.sv | 22 ++
 rtl/io_intr_timer.sv | 123 ++++++++++++
 tb/tb_io_intr_timer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/io_intr_timer_if.sv
// CPU data/IO bus between the CPU and the io_intr_timer peripheral,
// including the intr/inta handshake pair.
interface io_intr_timer_if;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_address;
    logic [31:0] io_d_in;
    logic [31:0] io_out;
    logic        intr;
    logic        inta;

    modport master (
        output io_cs, io_rd, io_wr, io_address, io_d_in, inta,
        input  io_out, intr
    );

    modport slave (
        input  io_cs, io_rd, io_wr, io_address, io_d_in, inta,
        output io_out, intr
    );
endinterface

// File: rtl/io_intr_timer.sv
// Memory-mapped peripheral: 32-bit scratch RAM plus a programmable down-counter
// that raises intr and completes a two-phase intr/inta handshake with the CPU.
module io_intr_timer #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    io_intr_timer_if.slave  bus
);
    localparam int unsigned AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_REQ, S_SVC} state_t;

    state_t           state;
    logic             en;
    logic             auto_rl;
    logic             intr_q;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic [7:0]       ackcnt;
    logic [31:0]      mem [RAM_WORDS];
    logic [31:0]      rdata;
    logic [AW-1:0]    ram_idx;
    logic             rd_en, wr_en;
    logic             ram_sel, ctrl_sel, period_sel, count_sel, status_sel;
    logic             ctrl_wr;
    logic             unused_addr;

    assign rd_en      = bus.io_cs & bus.io_rd;
    assign wr_en      = bus.io_cs & bus.io_wr;
    assign ram_sel    = (bus.io_address[11:10] == 2'b00);
    assign ctrl_sel   = (bus.io_address[11:2] == 10'h3FC);
    assign period_sel = (bus.io_address[11:2] == 10'h3FD);
    assign count_sel  = (bus.io_address[11:2] == 10'h3FE);
    assign status_sel = (bus.io_address[11:2] == 10'h3FF);
    assign ram_idx    = bus.io_address[2 +: AW];
    assign ctrl_wr    = wr_en & ctrl_sel;
    assign unused_addr = ^{bus.io_address[31:12], bus.io_address[1:0]};

    always_ff @(posedge clk) begin
        if (wr_en && ram_sel)
            mem[ram_idx] <= bus.io_d_in;
    end

    // Reads see the pre-edge registers, so a simultaneous read+write returns the old value.
    always_comb begin
        rdata = '0;
        if (ram_sel)
            rdata = mem[ram_idx];
        else if (ctrl_sel)
            rdata = {30'b0, auto_rl, en};
        else if (period_sel)
            rdata = 32'(period);
        else if (count_sel)
            rdata = 32'(count);
        else if (status_sel)
            rdata = {16'b0, ackcnt, 6'b0, (state == S_SVC), intr_q};
    end

    assign bus.io_out = rd_en ? rdata : 'z;
    assign bus.intr   = intr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            intr_q  <= 1'b0;
            period  <= '0;
            count   <= '0;
            ackcnt  <= '0;
        end else begin
            if (wr_en && period_sel)
                period <= bus.io_d_in[CNT_W-1:0];

            // A disabling CTRL write overrides everything, including a pending inta.
            if (ctrl_wr && !bus.io_d_in[0]) begin
                en      <= 1'b0;
                auto_rl <= bus.io_d_in[1];
                intr_q  <= 1'b0;
                state   <= S_IDLE;
            end else if (ctrl_wr && state == S_IDLE) begin
                en      <= 1'b1;
                auto_rl <= bus.io_d_in[1];
                count   <= period;
                state   <= S_COUNT;
            end else begin
                if (ctrl_wr)
                    auto_rl <= bus.io_d_in[1];
                case (state)
                    S_COUNT: begin
                        if (count <= CNT_W'(1)) begin
                            state  <= S_REQ;
                            intr_q <= 1'b1;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                    S_REQ: begin
                        if (bus.inta) begin
                            state  <= S_SVC;
                            intr_q <= 1'b0;
                            ackcnt <= ackcnt + 8'd1;
                        end
                    end
                    S_SVC: begin
                        if (!bus.inta) begin
                            if (auto_rl) begin
                                count <= period;
                                state <= S_COUNT;
                            end else begin
                                en    <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_intr_timer.sv
// Directed bench for io_intr_timer: stimulus pushes expectations into a
// scoreboard queue, a negedge monitor pops and compares.
module tb_io_intr_timer;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] hiz;

    io_intr_timer_if bus();

    io_intr_timer #(.RAM_WORDS(256), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_intr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    bit   obs = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(negedge clk) begin
        exp_t e;
        if (obs) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_empty: observation with no expectation queued");
            end else begin
                e = sb.pop_front();
                if (e.is_intr) begin
                    if (bus.intr !== e.exp[0])
                        $display("FAIL %s: intr=%b expected %b", e.name, bus.intr, e.exp[0]);
                    else
                        n_pass++;
                end else begin
                    if (bus.io_out !== e.exp)
                        $display("FAIL %s: io_out=%h expected %h", e.name, bus.io_out, e.exp);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic cycle(input bit cs, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit chk, input bit is_intr,
                         input logic [31:0] exp, input string name);
        exp_t e;
        bus.io_cs      = cs;
        bus.io_rd      = rd;
        bus.io_wr      = wr;
        bus.io_address = a;
        bus.io_d_in    = d;
        if (chk) begin
            e.is_intr = is_intr;
            e.exp     = exp;
            e.name    = name;
            sb.push_back(e);
            obs = 1'b1;
        end
        @(posedge clk);
        #1;
        obs       = 1'b0;
        bus.io_cs = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, 1'b1, a, d, 1'b0, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        cycle(1'b1, 1'b1, 1'b0, a, '0, 1'b1, 1'b0, exp, name);
    endtask

    task automatic ci(input bit exp, input string name);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, {31'b0, exp}, name);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, "");
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hiz            = 'z;
        reset          = 1'b0;
        bus.io_cs      = 1'b0;
        bus.io_rd      = 1'b0;
        bus.io_wr      = 1'b0;
        bus.io_address = '0;
        bus.io_d_in    = '0;
        bus.inta       = 1'b0;

        // Test 1: reset state and high-impedance read path
        pulse_reset();
        rd(32'hFF0, 32'h0, "rst_ctrl");
        rd(32'hFF4, 32'h0, "rst_period");
        rd(32'hFF8, 32'h0, "rst_count");
        rd(32'hFFC, 32'h0, "rst_status");
        ci(1'b0, "rst_intr");
        cycle(1'b0, 1'b1, 1'b0, 32'hFF0, '0, 1'b1, 1'b0, hiz, "hiz_no_cs");
        cycle(1'b1, 1'b0, 1'b0, 32'hFF0, '0, 1'b1, 1'b0, hiz, "hiz_no_rd");

        // Test 2: RAM, address aliasing, unmapped and read-only registers
        wr(32'h004, 32'hDEADBEEF);
        wr(32'h008, 32'h12345678);
        rd(32'h004, 32'hDEADBEEF, "ram_rd");
        rd(32'h006, 32'hDEADBEEF, "ram_byte_alias");
        rd(32'h008, 32'h12345678, "ram_word2");
        rd(32'h800, 32'h0, "unmapped_rd");
        wr(32'hC00, 32'hFFFFFFFF);
        rd(32'hC00, 32'h0, "unmapped_wr");
        cycle(1'b1, 1'b1, 1'b1, 32'hFF4, 32'h7, 1'b1, 1'b0, 32'h0, "rdwr_pre");
        rd(32'hFF4, 32'h7, "rdwr_post");
        wr(32'hFF8, 32'h5);
        rd(32'hFF8, 32'h0, "count_ro");
        wr(32'hFFC, 32'hFFFFFFFF);
        rd(32'hFFC, 32'h0, "status_ro");

        // Test 3: one-shot, PERIOD=3
        wr(32'hFF4, 32'h3);
        wr(32'hFF0, 32'h1);
        rd(32'hFF8, 32'h3, "t3_cnt_load");
        ci(1'b0, "t3_n1");
        ci(1'b0, "t3_n2");
        ci(1'b1, "t3_n3");
        ci(1'b1, "t3_hold");
        bus.inta = 1'b1;
        ci(1'b1, "t3_req_inta");
        bus.inta = 1'b0;
        rd(32'hFFC, 32'h102, "t3_svc_status");
        rd(32'hFFC, 32'h100, "t3_ackcnt");
        ci(1'b0, "t3_idle_intr");
        rd(32'hFF0, 32'h0, "t3_ctrl_cleared");

        // Test 4: auto-reload, PERIOD=2, three acknowledges
        pulse_reset();
        wr(32'hFF4, 32'h2);
        wr(32'hFF0, 32'h3);
        ci(1'b0, "t4_n0");
        ci(1'b0, "t4_n1");
        ci(1'b1, "t4_n2");
        for (int i = 0; i < 3; i++) begin
            bus.inta = 1'b1;
            ci(1'b1, "t4_ack_req");
            bus.inta = 1'b0;
            ci(1'b0, "t4_ack_drop");
            ci(1'b0, "t4_reload");
            ci(1'b0, "t4_count");
            ci(1'b1, "t4_auto_req");
        end
        rd(32'hFFC, 32'h301, "t4_status");
        rd(32'hFF0, 32'h3, "t4_ctrl");
        wr(32'hFF0, 32'h1);
        rd(32'hFF0, 32'h1, "t4_auto_update");
        ci(1'b1, "t4_no_restart");
        wr(32'hFF0, 32'h0);
        ci(1'b0, "t4_disable");
        rd(32'hFFC, 32'h300, "t4_status_off");

        // Test 5: PERIOD=0 acts as 1; disable wins over coincident inta
        wr(32'hFF4, 32'h0);
        wr(32'hFF0, 32'h1);
        ci(1'b0, "t5_n0");
        ci(1'b1, "t5_n1");
        bus.inta = 1'b1;
        wr(32'hFF0, 32'h0);
        bus.inta = 1'b0;
        ci(1'b0, "t5_off");
        rd(32'hFFC, 32'h300, "t5_ack_unchanged");

        // Test 6: reset during an active request
        wr(32'hFF4, 32'h1);
        wr(32'hFF0, 32'h1);
        ci(1'b0, "t6_n0");
        ci(1'b1, "t6_n1");
        reset = 1'b0;
        ci(1'b1, "t6_pre_reset");
        reset = 1'b1;
        ci(1'b0, "t6_intr_drop");
        rd(32'hFF8, 32'h0, "t6_count");
        rd(32'hFFC, 32'h0, "t6_status");
        rd(32'h004, 32'hDEADBEEF, "t6_ram_kept");

        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, "");
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
